// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap, saturate and one-shot modes.
//
// Parameters:
//   WIDTH     counter width in bits (2..32)
//   MAX_VAL   terminal count for up-counting (1..2**WIDTH-1)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         count enable
//   load       synchronous load strobe (wins over en)
//   load_data  value to load, clamped to MAX_VAL
//   dir        1 = up, 0 = down
//   mode       00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   cmp_val    compare value for match
//   oe         output enable
//   q          counter register
//   q_out      q gated by oe
//   q_oe       oe replicated across WIDTH bits
//   tc         terminal-count step flag (combinational)
//   match      q == cmp_val (combinational)
//   done       high while the one-shot FSM is in its DONE state
module prog_counter #(
  parameter int unsigned     WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             oe,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] q_oe,
  output logic             tc,
  output logic             match,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [WIDTH-1:0] Zero = '0;
  localparam logic [WIDTH-1:0] One  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             term;
  logic             one_shot;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;

  always_comb begin
    one_shot = (mode == 2'b10);
    term     = dir ? (q_q == MAX_VAL) : (q_q == Zero);
    // Wrapping step; saturate and one-shot only use it away from the terminal value.
    if (dir) begin
      step_val = (q_q == MAX_VAL) ? Zero : q_q + One;
    end else begin
      step_val = (q_q == Zero) ? MAX_VAL : q_q - One;
    end
    load_val = (load_data > MAX_VAL) ? MAX_VAL : load_data;
  end

  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    if (load) begin
      q_d     = load_val;
      state_d = one_shot ? StRun : StIdle;
    end else begin
      if (!one_shot) begin
        state_d = StIdle;
      end
      if (en) begin
        case (mode)
          2'b01: begin
            if (!term) q_d = step_val;
          end
          2'b10: begin
            if (state_q == StRun) begin
              // Terminal value is reached and held; the next enabled edge finishes the run.
              if (term) state_d = StDone;
              else      q_d     = step_val;
            end
          end
          default: q_d = step_val;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= Zero;
      state_q <= StIdle;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    q     = q_q;
    q_out = oe ? q_q : Zero;
    q_oe  = {WIDTH{oe}};
    match = (q_q == cmp_val);
    tc    = en & ~load & term & (~one_shot | (state_q == StRun));
    done  = (state_q == StDone);
  end

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter (WIDTH=8, MAX_VAL=9).
// Each record holds the inputs for one cycle and the outputs expected just
// before the rising edge that consumes those inputs.
module tb_prog_counter;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic         rst;
    logic         load;
    logic [W-1:0] load_data;
    logic         en;
    logic         dir;
    logic [1:0]   mode;
    logic         oe;
    logic [W-1:0] cmp_val;
    logic [W-1:0] exp_q;
    logic         exp_tc;
    logic         exp_done;
    logic         exp_match;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, en, load, dir, oe;
  logic [W-1:0] load_data, cmp_val;
  logic [1:0]   mode;
  logic [W-1:0] q, q_out, q_oe;
  logic         tc, match, done;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];
  vec_t sb[$];

  prog_counter #(.WIDTH(W), .MAX_VAL(8'd9)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .load_data (load_data),
    .dir       (dir),
    .mode      (mode),
    .cmp_val   (cmp_val),
    .oe        (oe),
    .q         (q),
    .q_out     (q_out),
    .q_oe      (q_oe),
    .tc        (tc),
    .match     (match),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic r, input logic ld, input logic [W-1:0] data,
                              input logic e, input logic d, input logic [1:0] m,
                              input logic o, input logic [W-1:0] eq, input logic et,
                              input logic ed);
    vec_t v;
    v.rst       = r;
    v.load      = ld;
    v.load_data = data;
    v.en        = e;
    v.dir       = d;
    v.mode      = m;
    v.oe        = o;
    v.cmp_val   = 8'd5;
    v.exp_q     = eq;
    v.exp_tc    = et;
    v.exp_done  = ed;
    v.exp_match = (eq == 8'd5);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d required %0d", name, $time, act, exp);
    end
  endtask

  // Drive one record after the falling edge, queue its expectation, then
  // compare the settled outputs shortly before the next rising edge.
  task automatic drive(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst       = v.rst;
    load      = v.load;
    load_data = v.load_data;
    en        = v.en;
    dir       = v.dir;
    mode      = v.mode;
    oe        = v.oe;
    cmp_val   = v.cmp_val;
    sb.push_back(v);
    #4;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("q", 32'(q), 32'(e.exp_q));
      chk("tc", 32'(tc), 32'(e.exp_tc));
      chk("done", 32'(done), 32'(e.exp_done));
      chk("match", 32'(match), 32'(e.exp_match));
      chk("q_out", 32'(q_out), e.oe ? 32'(e.exp_q) : 32'd0);
      chk("q_oe", 32'(q_oe), e.oe ? 32'hff : 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; load_data = '0;
    dir = 1'b1; mode = 2'b00; oe = 1'b0; cmp_val = 8'd5;
    repeat (2) @(posedge clk);

    // Reset overrides load/en; tc still follows its definition on q=0.
    vecs.push_back(mk(1, 1, 7,   1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,   1, 0, 0, 0, 0, 1, 0));
    // Wrap up 12 cycles, oe toggling.
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] qv;
      qv = (i < 10) ? W'(i) : W'(i - 10);
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, i[0], qv, qv == 8'd9, 0));
    end
    vecs.push_back(mk(0, 0, 0,   0, 1, 0, 1, 2, 0, 0));
    // Wrap down through zero.
    vecs.push_back(mk(0, 0, 0,   1, 0, 0, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0,   1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 1, 9, 0, 0));
    // Mode 11 behaves as wrap.
    vecs.push_back(mk(0, 0, 0,   1, 1, 3, 1, 9, 1, 0));
    vecs.push_back(mk(0, 0, 0,   0, 1, 3, 0, 0, 0, 0));
    // Saturate down from 3.
    vecs.push_back(mk(0, 1, 3,   0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,   1, 0, 1, 1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0,   1, 0, 1, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0,   1, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,   1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 1, 0, 0, 0));
    // Load beats en; load_data clamped to MAX_VAL.
    vecs.push_back(mk(0, 1, 200, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4,   1, 1, 0, 1, 9, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 1, 0, 1, 4, 0, 0));
    // Saturate up at MAX_VAL.
    vecs.push_back(mk(0, 1, 8,   0, 1, 1, 1, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0,   1, 1, 1, 1, 8, 0, 0));
    vecs.push_back(mk(0, 0, 0,   1, 1, 1, 1, 9, 1, 0));
    vecs.push_back(mk(0, 0, 0,   1, 1, 1, 1, 9, 1, 0));
    vecs.push_back(mk(0, 0, 0,   0, 1, 1, 1, 9, 0, 0));

    foreach (vecs[i]) drive(vecs[i]);

    // One-shot: idle does not count, run to 9, done, reload restarts.
    drive(mk(0, 0, 0, 1, 1, 2, 1, 9, 0, 0));
    drive(mk(0, 1, 7, 1, 1, 2, 1, 9, 0, 0));
    drive(mk(0, 0, 0, 1, 1, 2, 1, 7, 0, 0));
    drive(mk(0, 0, 0, 1, 1, 2, 1, 8, 0, 0));
    drive(mk(0, 0, 0, 1, 1, 2, 1, 9, 1, 0));
    drive(mk(0, 0, 0, 1, 1, 2, 1, 9, 0, 1));
    drive(mk(0, 0, 0, 1, 1, 2, 0, 9, 0, 1));
    drive(mk(0, 1, 2, 0, 1, 2, 1, 9, 0, 1));
    drive(mk(0, 0, 0, 1, 1, 2, 1, 2, 0, 0));
    drive(mk(0, 0, 0, 1, 1, 2, 1, 3, 0, 0));
    // Reset mid-run at q=4 aborts; no counting afterwards until a load.
    drive(mk(1, 0, 0, 1, 1, 2, 1, 4, 0, 0));
    drive(mk(0, 0, 0, 1, 1, 2, 1, 0, 0, 0));
    drive(mk(0, 0, 0, 1, 0, 2, 1, 0, 0, 0));
    // One-shot counting down to zero.
    drive(mk(0, 1, 2, 0, 0, 2, 1, 0, 0, 0));
    drive(mk(0, 0, 0, 1, 0, 2, 1, 2, 0, 0));
    drive(mk(0, 0, 0, 1, 0, 2, 1, 1, 0, 0));
    drive(mk(0, 0, 0, 1, 0, 2, 1, 0, 1, 0));
    drive(mk(0, 0, 0, 1, 0, 2, 1, 0, 0, 1));
    // Leaving one-shot mode clears done on the next edge.
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    // en=0 holds in RUN.
    drive(mk(0, 1, 5, 0, 1, 2, 1, 0, 0, 0));
    drive(mk(0, 0, 0, 0, 1, 2, 1, 5, 0, 0));
    drive(mk(0, 0, 0, 1, 1, 2, 1, 5, 0, 0));
    drive(mk(0, 0, 0, 0, 1, 2, 1, 6, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
